// File: rtl/num2text_tx.sv
// Binary-to-decimal ASCII serializer: double-dabble conversion, then one digit per transfer, MSD first.
// Latency: out_valid rises W cycles after the accept edge; each further digit follows with no bubble.
// Backpressure: out_ready low holds out_chr/out_last; in_ready is high only while idle.
module num2text_tx #(
    parameter int W  = 8,
    parameter int ND = 3
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_chr,
    output logic         out_last,
    output logic         busy
);

    localparam int SW = 4*ND + W;
    localparam int PW = (ND > 1) ? $clog2(ND) : 1;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

    state_t        state;
    logic [SW-1:0] sr;
    logic [SW-1:0] sr_nx;
    logic [CW-1:0] cnt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nx;

    // One double-dabble step: correct every BCD digit >= 5, then shift {bcd, bin} left.
    function automatic logic [SW-1:0] dabble(input logic [SW-1:0] s);
        logic [SW-1:0] t;
        t = s;
        for (int i = 0; i < ND; i++) begin
            if (t[W+4*i +: 4] >= 4'd5)
                t[W+4*i +: 4] = t[W+4*i +: 4] + 4'd3;
        end
        return {t[SW-2:0], 1'b0};
    endfunction

    // Index of the most significant non-zero digit; 0 when the value is zero.
    function automatic logic [PW-1:0] msd(input logic [4*ND-1:0] b);
        logic [PW-1:0] m;
        m = '0;
        for (int i = 0; i < ND; i++) begin
            if (b[4*i +: 4] != 4'd0)
                m = PW'(i);
        end
        return m;
    endfunction

    function automatic logic [7:0] chr(input logic [SW-1:0] s, input logic [PW-1:0] p);
        return 8'h30 + {4'h0, s[W + 4*int'(p) +: 4]};
    endfunction

    assign sr_nx  = dabble(sr);
    assign ptr_nx = msd(sr_nx[SW-1:W]);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            ptr       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_chr   <= 8'h00;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_ready && in_valid) begin
                        sr       <= {{(4*ND){1'b0}}, in_data};
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    sr  <= sr_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state     <= SEND;
                        ptr       <= ptr_nx;
                        out_valid <= 1'b1;
                        out_chr   <= chr(sr_nx, ptr_nx);
                        out_last  <= (ptr_nx == '0);
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (ptr != '0) begin
                            ptr      <= ptr - 1'b1;
                            out_chr  <= chr(sr, ptr - 1'b1);
                            out_last <= (ptr == PW'(1));
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_chr   <= 8'h00;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_b && out_valid)
            assert (out_chr >= 8'h30 && out_chr <= 8'h39);
    end
`endif

endmodule

// File: tb/tb_num2text_tx.sv
// Bench for num2text_tx: directed scenarios plus randomized values and backpressure against a decimal-string model.
module tb_num2text_tx;
    localparam int W  = 8;
    localparam int ND = 3;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, out_last, busy;
    logic [7:0]   out_chr;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] got_c[$];
    logic       got_l[$];
    logic [7:0] exp_c[$];
    logic       exp_l[$];

    num2text_tx #(.W(W), .ND(ND)) dut (
        .clk(clk), .rst_b(rst_b),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_chr(out_chr),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Record every completed transfer; inputs settle long before the falling edge.
    always @(negedge clk) begin
        if (rst_b && out_valid && out_ready) begin
            got_c.push_back(out_chr);
            got_l.push_back(out_last);
        end
    end

    // Reference: decimal digits of v by repeated division, MSD first, last flag on the final one.
    function automatic void model_push(input int v);
        logic [7:0] d[$];
        int x;
        x = v;
        d = {};
        if (x == 0) d.push_back(8'h30);
        while (x > 0) begin
            d.push_front(8'(48 + x % 10));
            x = x / 10;
        end
        foreach (d[i]) begin
            exp_c.push_back(d[i]);
            exp_l.push_back(i == d.size() - 1);
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q;
        got_c = {}; got_l = {}; exp_c = {}; exp_l = {};
    endtask

    task automatic send(input logic [W-1:0] v, output bit ok);
        logic r;
        in_data = v;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            r = in_ready;
            tick;
            if (r) ok = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (!in_ready && cyc < 200) begin
            tick;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_b = 1'b0;
        #2;
        n_chk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_chr !== 8'h00 || out_last !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_vals got rdy=%b vld=%b chr=%h last=%b busy=%b want 0 0 00 0 0",
                     in_ready, out_valid, out_chr, out_last, busy);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst_b = 1'b1;
        tick;
        n_chk++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL reset_release got rdy=%b busy=%b vld=%b want 1 0 0", in_ready, busy, out_valid);
        else n_pass++;
    endtask

    task automatic test_zero;
        bit ok;
        int lat, cyc;
        out_ready = 1'b1;
        clear_q;
        model_push(0);
        send(8'd0, ok);
        n_chk++;
        if (!ok) $display("FAIL zero_accept got timeout want accept"); else n_pass++;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick;
            lat++;
        end
        n_chk++;
        if (lat != W) $display("FAIL zero_latency got %0d want %0d", lat, W); else n_pass++;
        wait_idle(cyc);
        n_chk++;
        if (got_c.size() != exp_c.size()) $display("FAIL zero_len got %0d want %0d", got_c.size(), exp_c.size());
        else n_pass++;
        for (int i = 0; i < got_c.size() && i < exp_c.size(); i++) begin
            n_chk++;
            if (got_c[i] !== exp_c[i] || got_l[i] !== exp_l[i])
                $display("FAIL zero_chr[%0d] got %h/%b want %h/%b", i, got_c[i], got_l[i], exp_c[i], exp_l[i]);
            else n_pass++;
        end
    endtask

    task automatic test_known;
        bit ok;
        int cyc;
        int vals[3] = '{255, 100, 7};
        out_ready = 1'b1;
        foreach (vals[j]) begin
            clear_q;
            model_push(vals[j]);
            send(W'(vals[j]), ok);
            wait_idle(cyc);
            n_chk++;
            if (!ok || cyc != W + exp_c.size())
                $display("FAIL known_%0d_cycles got %0d want %0d", vals[j], cyc, W + exp_c.size());
            else n_pass++;
            n_chk++;
            if (got_c.size() != exp_c.size())
                $display("FAIL known_%0d_len got %0d want %0d", vals[j], got_c.size(), exp_c.size());
            else n_pass++;
            for (int i = 0; i < got_c.size() && i < exp_c.size(); i++) begin
                n_chk++;
                if (got_c[i] !== exp_c[i] || got_l[i] !== exp_l[i])
                    $display("FAIL known_%0d_chr[%0d] got %h/%b want %h/%b", vals[j], i,
                             got_c[i], got_l[i], exp_c[i], exp_l[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall;
        bit ok;
        int cyc;
        out_ready = 1'b0;
        clear_q;
        model_push(42);
        send(8'd42, ok);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick;
            cyc++;
        end
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_chr !== 8'h34 || out_last !== 1'b0)
                $display("FAIL stall_hold[%0d] got %b/%h/%b want 1/34/0", k, out_valid, out_chr, out_last);
            else n_pass++;
            tick;
        end
        out_ready = 1'b1;
        wait_idle(cyc);
        n_chk++;
        if (got_c.size() != 2) $display("FAIL stall_len got %0d want 2", got_c.size()); else n_pass++;
        for (int i = 0; i < got_c.size() && i < exp_c.size(); i++) begin
            n_chk++;
            if (got_c[i] !== exp_c[i] || got_l[i] !== exp_l[i])
                $display("FAIL stall_chr[%0d] got %h/%b want %h/%b", i, got_c[i], got_l[i], exp_c[i], exp_l[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic r;
        int cyc;
        out_ready = 1'b1;
        clear_q;
        model_push(12);
        model_push(34);
        in_data = 8'd12;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            r = in_ready;
            tick;
            if (r) ok = 1'b1;
        end
        in_data = 8'd9;
        // 12 occupies W conversion cycles plus 2 send cycles; in_valid stays high throughout.
        for (int k = 0; k < W + 2; k++) begin
            n_chk++;
            if (in_ready !== 1'b0) $display("FAIL busy_rdy[%0d] got %b want 0", k, in_ready); else n_pass++;
            if (out_valid && out_last) in_data = 8'd34;
            tick;
        end
        n_chk++;
        if (in_ready !== 1'b1 || !ok) $display("FAIL b2b_ready got %b want 1", in_ready); else n_pass++;
        tick;
        in_valid = 1'b0;
        wait_idle(cyc);
        n_chk++;
        if (got_c.size() != exp_c.size()) $display("FAIL b2b_len got %0d want %0d", got_c.size(), exp_c.size());
        else n_pass++;
        for (int i = 0; i < got_c.size() && i < exp_c.size(); i++) begin
            n_chk++;
            if (got_c[i] !== exp_c[i] || got_l[i] !== exp_l[i])
                $display("FAIL b2b_chr[%0d] got %h/%b want %h/%b", i, got_c[i], got_l[i], exp_c[i], exp_l[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int cyc;
        logic seen;
        out_ready = 1'b1;
        clear_q;
        send(8'd255, ok);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick;
            cyc++;
        end
        tick;
        n_chk++;
        if (out_chr !== 8'h35 || out_valid !== 1'b1)
            $display("FAIL rmid_second got %b/%h want 1/35", out_valid, out_chr);
        else n_pass++;
        rst_b = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL rmid_async got vld=%b rdy=%b busy=%b want 0 0 0", out_valid, in_ready, busy);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst_b = 1'b1;
        seen = 1'b0;
        tick;
        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", in_ready); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            if (out_valid) seen = 1'b1;
            tick;
        end
        n_chk++;
        if (seen || got_c.size() != 1 || got_c[0] !== 8'h32)
            $display("FAIL rmid_abort got n=%0d seen_vld=%b want n=1 chr=32 no_vld", got_c.size(), seen);
        else n_pass++;
        clear_q;
        model_push(5);
        send(8'd5, ok);
        wait_idle(cyc);
        n_chk++;
        if (got_c.size() != 1 || got_c[0] !== 8'h35 || got_l[0] !== 1'b1)
            $display("FAIL rmid_after got n=%0d want single 35/1", got_c.size());
        else n_pass++;
    endtask

    task automatic test_random;
        logic [W-1:0] vals[30];
        int idx;
        logic rdy_prev, pv, pl;
        logic [7:0] pc;
        clear_q;
        foreach (vals[i]) vals[i] = W'($urandom_range(0, 255));
        idx = 0; rdy_prev = 1'b0; pv = 1'b0; pc = 8'h00; pl = 1'b0;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (in_valid && rdy_prev) begin
                model_push(int'(vals[idx]));
                idx++;
                in_valid = 1'b0;
            end
            if (pv) begin
                n_chk++;
                if (out_valid !== 1'b1 || out_chr !== pc || out_last !== pl)
                    $display("FAIL rnd_hold got %b/%h/%b want 1/%h/%b", out_valid, out_chr, out_last, pc, pl);
                else n_pass++;
            end
            if (idx == 30 && !in_valid && in_ready) break;
            out_ready = ($urandom_range(0, 2) != 0);
            pv = out_valid && !out_ready;
            pc = out_chr;
            pl = out_last;
            if (!in_valid && idx < 30 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data = vals[idx];
            end
            rdy_prev = in_ready;
            tick;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_chk++;
        if (idx != 30 || got_c.size() != exp_c.size())
            $display("FAIL rnd_len got %0d vals / %0d chars want 30 / %0d", idx, got_c.size(), exp_c.size());
        else n_pass++;
        for (int i = 0; i < got_c.size() && i < exp_c.size(); i++) begin
            n_chk++;
            if (got_c[i] !== exp_c[i] || got_l[i] !== exp_l[i])
                $display("FAIL rnd_chr[%0d] got %h/%b want %h/%b", i, got_c[i], got_l[i], exp_c[i], exp_l[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_known;
        test_stall;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
